// File: rtl/fa_bist_checker.sv
// fa_bist_checker: BIST engine that steps a 1-bit full adder through all 8 vectors and checks S/Cout
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             Cin,
  input  logic             S,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FIN} state_t;
  state_t state, state_n;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic go, mismatch;
  assign go = start && (state == IDLE || state == FIN);
  assign mismatch = {S, Cout} != {^vec, (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0])};
  assign {A, B, Cin} = vec;
  assign pass = done && err_count == '0;
  always_comb begin
    state_n = state;
    if (go) state_n = SETTLE;
    else if (state == SETTLE) state_n = cnt == 4'(SETTLE_CYCLES - 1) ? CHECK : SETTLE;
    else if (state == CHECK) state_n = vec == 3'd7 ? FIN : SETTLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      fail_valid <= 1'b0;
      fail_vec <= '0;
    end else begin
      state <= state_n;
      busy <= state_n == SETTLE || state_n == CHECK;
      done <= state_n == FIN;
      if (go) begin
        vec <= '0;
        cnt <= '0;
        err_count <= '0;
        fail_valid <= 1'b0;
        fail_vec <= '0;
      end
      if (state == SETTLE) cnt <= cnt + 4'd1;
      if (state == CHECK) begin
        if (mismatch) begin
          if (~&err_count) err_count <= err_count + ERR_W'(1);
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec <= vec;
          end
        end
        if (vec != 3'd7) begin
          vec <= vec + 3'd1;
          cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fa_bist_checker.sv
// tb_fa_bist_checker: directed bench for fa_bist_checker with ideal and faulty adder models
module tb_fa_bist_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic a, b, cin, s, cout, busy, done, pass, fv;
  logic [3:0] err;
  logic [2:0] fvec;
  logic a2, b2, cin2, s2, cout2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [2:0] fvec2;
  int mode = 0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  function automatic logic [1:0] adder(input logic x, y, z, input int m);
    logic [1:0] sum;
    sum = 2'(x) + 2'(y) + 2'(z);
    return {m == 2 ? ~sum[0] : sum[0], m == 1 ? 1'b0 : sum[1]};
  endfunction
  always_comb {s, cout} = adder(a, b, cin, mode);
  always_comb {s2, cout2} = adder(a2, b2, cin2, mode);
  fa_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err), .fail_valid(fv), .fail_vec(fvec));
  fa_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a2), .B(b2), .Cin(cin2), .S(s2), .Cout(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_done(input int e0);
    int e = e0;
    while (!done && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("latency", e, 24);
  endtask
  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec", {a, b, cin}, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", done, 0);
    pulse_start();
    chk("vec_0", {a, b, cin}, 0);
    chk("busy_0", busy, 1);
    for (int k = 1; k < 24; k++) begin
      @(negedge clk);
      if (k % 3 == 0) chk("vec_step", {a, b, cin}, k / 3);
      if (k == 12) chk("busy_mid", busy, 1);
      if (k == 23) chk("done_early", done, 0);
    end
    @(negedge clk);
    chk("ideal_done", done, 1);
    chk("ideal_busy", busy, 0);
    chk("ideal_pass", pass, 1);
    chk("ideal_err", err, 0);
    chk("ideal_fv", fv, 0);
    chk("ideal_last", {a, b, cin}, 7);
    mode = 1;
    pulse_start();
    chk("restart_done", done, 0);
    wait_done(0);
    chk("cout0_err", err, 4);
    chk("cout0_fvec", fvec, 3);
    chk("cout0_fv", fv, 1);
    chk("cout0_pass", pass, 0);
    mode = 2;
    pulse_start();
    wait_done(0);
    chk("sinv_err", err, 8);
    chk("sinv_fvec", fvec, 0);
    chk("sinv_err_sat", err2, 3);
    chk("sinv_fv2", fv2, 1);
    mode = 0;
    pulse_start();
    chk("clr_err", err, 0);
    chk("clr_fv", fv, 0);
    chk("clr_busy", busy, 1);
    wait_done(0);
    chk("recov_pass", pass, 1);
    chk("recov_err", err, 0);
    pulse_start();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done(11);
    chk("ign_pass", pass, 1);
    chk("ign_vec", {a, b, cin}, 7);
    @(negedge clk);
    chk("done_hold", done, 1);
    mode = 1;
    pulse_start();
    repeat (12) @(negedge clk);
    chk("vec_100", {a, b, cin}, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", {a, b, cin}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_fv", fv, 0);
    chk("mid_rst_fvec", fvec, 0);
    chk("mid_rst_pass", pass, 0);
    mode = 0;
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    wait_done(0);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_err", err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
